// File: rtl/fir_sched_pkg.sv
// Shared types and sizing helpers for the FIR channel scheduler.
// Imported by the scheduler top and its arbiter.
package fir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  localparam int NUM_CH_DEF    = 4;
  localparam int CH_W          = $clog2(NUM_CH_DEF);
  localparam int FRAME_CYC_DEF = 16;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_ch_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 with wrap.
// Returns a one-hot grant, its index and an any-grant flag.
module rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = cnt_w(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  int           j;
  logic [W-1:0] jw;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    j     = 0;
    jw    = '0;
    for (int i = 1; i <= N; i++) begin
      j = int'(i_ptr) + i;
      if (j >= N) j = j - N;
      jw = W'(j);
      if (!o_any && i_req[jw]) begin
        o_any     = 1'b1;
        o_gnt[jw] = 1'b1;
        o_idx     = jw;
      end
    end
  end

endmodule

// File: rtl/fir_ch_scheduler.sv
// Shares one serial FIR core among NUM_CH channels: arbitrate, load,
// run a fixed frame, then park the result in a one-entry output buffer.
module fir_ch_scheduler
  import fir_sched_pkg::*;
#(
  parameter  int NUM_CH    = NUM_CH_DEF,
  parameter  int DATA_W    = 18,
  parameter  int FRAME_CYC = FRAME_CYC_DEF,
  localparam int CW        = cnt_w(NUM_CH),
  localparam int KW        = cnt_w(FRAME_CYC)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic [NUM_CH-1:0]        i_ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
  output logic [NUM_CH-1:0]        o_ch_ready,
  output logic                     o_flt_load,
  output logic [DATA_W-1:0]        o_flt_data,
  output logic [CW-1:0]            o_flt_ctx,
  output logic                     o_flt_run,
  input  logic [DATA_W-1:0]        i_flt_result,
  output logic                     o_res_valid,
  output logic [DATA_W-1:0]        o_res_data,
  output logic [CW-1:0]            o_res_ch,
  input  logic                     i_res_ready,
  output logic                     o_busy
);

  localparam logic [KW-1:0] CNT_LAST = KW'(FRAME_CYC - 1);

  state_e            state_q, state_d;
  logic [KW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     ctx_q, ctx_d;
  logic [CW-1:0]     rch_q, rch_d;
  logic [DATA_W-1:0] fdat_q, fdat_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              rval_q, rval_d;
  logic              load_q, load_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;

  logic [NUM_CH-1:0] gnt;
  logic [CW-1:0]     gnt_idx;
  logic              gnt_any;
  logic              grant_ok;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .i_req (i_ch_valid),
    .i_ptr (ptr_q),
    .o_gnt (gnt),
    .o_idx (gnt_idx),
    .o_any (gnt_any)
  );

  // The buffer may be drained and re-granted in the same cycle.
  assign grant_ok = !i_rst && (state_q == IDLE) && i_enable
                 && (!rval_q || i_res_ready);
  assign o_ch_ready = grant_ok ? gnt : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    ctx_d   = ctx_q;
    fdat_d  = fdat_q;
    rch_d   = rch_q;
    rdat_d  = rdat_q;
    rval_d  = rval_q;
    if (rval_q && i_res_ready) rval_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_ok && gnt_any) begin
          fdat_d  = i_ch_data[int'(gnt_idx)*DATA_W +: DATA_W];
          ctx_d   = gnt_idx;
          ptr_d   = gnt_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          rdat_d  = i_flt_result;
          rch_d   = ctx_q;
          rval_d  = 1'b1;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    load_d = (state_d == LOAD);
    run_d  = (state_d == RUN);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= CW'(NUM_CH - 1);
      ctx_q   <= '0;
      fdat_q  <= '0;
      rch_q   <= '0;
      rdat_q  <= '0;
      rval_q  <= 1'b0;
      load_q  <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ctx_q   <= ctx_d;
      fdat_q  <= fdat_d;
      rch_q   <= rch_d;
      rdat_q  <= rdat_d;
      rval_q  <= rval_d;
      load_q  <= load_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
    end
  end

  assign o_flt_load  = load_q;
  assign o_flt_run   = run_q;
  assign o_flt_data  = fdat_q;
  assign o_flt_ctx   = ctx_q;
  assign o_res_valid = rval_q;
  assign o_res_data  = rdat_q;
  assign o_res_ch    = rch_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_fir_ch_scheduler.sv
// Bench for fir_ch_scheduler: timeline model of grants/frames/results,
// directed scenarios with literal checks, then randomized traffic.
module tb_fir_ch_scheduler;

  localparam int N  = 4;
  localparam int DW = 18;
  localparam int F  = 16;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, en, rdy;
  logic [N-1:0]    vld;
  logic [N*DW-1:0] dat;
  logic [DW-1:0]   res_in;

  logic [N-1:0]  o_ch_ready;
  logic          o_flt_load, o_flt_run, o_res_valid, o_busy;
  logic [DW-1:0] o_flt_data, o_res_data;
  logic [CW-1:0] o_flt_ctx, o_res_ch;

  fir_ch_scheduler #(.NUM_CH(N), .DATA_W(DW), .FRAME_CYC(F)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (en),
    .i_ch_valid   (vld),
    .i_ch_data    (dat),
    .o_ch_ready   (o_ch_ready),
    .o_flt_load   (o_flt_load),
    .o_flt_data   (o_flt_data),
    .o_flt_ctx    (o_flt_ctx),
    .o_flt_run    (o_flt_run),
    .i_flt_result (res_in),
    .o_res_valid  (o_res_valid),
    .o_res_data   (o_res_data),
    .o_res_ch     (o_res_ch),
    .i_res_ready  (rdy),
    .o_busy       (o_busy)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic cmp(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    if (a !== e) begin
      nerr++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, a, e);
    end
  endtask

  // Model: a frame granted at cycle tg loads at tg+1, runs tg+2..tg+F+1,
  // captures at tg+F+1 and is busy through tg+F+2.
  int            cyc = 0;
  int            tg = -1;
  int            mptr = N - 1;
  bit            mbv = 0;
  logic [DW-1:0] mbd = '0;
  logic [DW-1:0] mfd = '0;
  int            mbch = 0;
  int            mfctx = 0;
  bit            chk_en = 0;

  always @(negedge clk) begin
    int d;
    int g;
    int j;
    logic [N-1:0] er;
    if (chk_en) begin
      d  = (tg >= 0) ? cyc - tg : 1000;
      er = '0;
      g  = -1;
      if (!rst && !(d >= 1 && d <= F + 2) && en && (!mbv || rdy))
        for (int i = 1; i <= N; i++) begin
          j = (mptr + i) % N;
          if (g < 0 && vld[j]) g = j;
        end
      if (g >= 0) er[g] = 1'b1;
      nvec++;
      cmp("ready", 64'(o_ch_ready), 64'(er));
      cmp("load", 64'(o_flt_load), 64'(d == 1));
      cmp("run", 64'(o_flt_run), 64'(d >= 2 && d <= F + 1));
      cmp("busy", 64'(o_busy), 64'(d >= 1 && d <= F + 2));
      cmp("flt_data", 64'(o_flt_data), 64'(mfd));
      cmp("flt_ctx", 64'(o_flt_ctx), 64'(mfctx));
      cmp("res_valid", 64'(o_res_valid), 64'(mbv));
      cmp("res_data", 64'(o_res_data), 64'(mbd));
      cmp("res_ch", 64'(o_res_ch), 64'(mbch));
      if (rst) begin
        tg = -1; mptr = N - 1; mbv = 0; mbd = '0;
        mbch = 0; mfd = '0; mfctx = 0;
      end else begin
        if (mbv && rdy) mbv = 0;
        if (d == F + 1) begin
          mbv = 1; mbd = res_in; mbch = mfctx;
        end
        if (g >= 0) begin
          tg = cyc; mptr = g; mfctx = g;
          mfd = dat[g*DW +: DW];
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_data();
    for (int k = 0; k < N; k++) dat[k*DW +: DW] = DW'($urandom);
  endtask

  task automatic wait_load(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (o_flt_load) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      nerr++;
      $display("FAIL wait_load timeout t=%0t", $time);
    end
  endtask

  task automatic one_result(input logic [DW-1:0] r, input string nm);
    bit seen;
    seen = 0;
    do_reset();
    vld = 4'b0001; rdy = 1'b1; en = 1'b1; res_in = r;
    rand_data();
    for (int i = 0; i < 40; i++) begin
      #1;
      if (o_res_valid) begin
        seen = 1;
        cmp(nm, 64'(o_res_data), 64'(r));
        break;
      end
      tick();
    end
    if (!seen) begin
      nerr++;
      $display("FAIL %s timeout t=%0t", nm, $time);
    end
  endtask

  initial begin
    int gc[$];
    int gv[$];
    int cnt;
    bit ok;
    logic [N-1:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1; en = 1'b0; rdy = 1'b0; vld = '0; dat = '0; res_in = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_en = 1;
    tick();

    // Single channel timeline
    rst = 1'b0; en = 1'b1; rdy = 1'b0; res_in = 18'h2ABCD;
    for (int n = 0; n <= 24; n++) begin
      vld = (n == 5) ? 4'b0001 : 4'b0000;
      dat = '0;
      if (n == 5) dat[DW-1:0] = 18'h00123;
      #1;
      if (n == 0) cmp("t1_reset_busy", 64'(o_busy), 64'h0);
      if (n == 5) cmp("t1_ready", 64'(o_ch_ready), 64'h1);
      if (n == 6) begin
        cmp("t1_load", 64'(o_flt_load), 64'h1);
        cmp("t1_fdata", 64'(o_flt_data), 64'h00123);
      end
      if (n == 7 || n == 22) cmp("t1_run", 64'(o_flt_run), 64'h1);
      if (n == 23) begin
        cmp("t1_rvalid", 64'(o_res_valid), 64'h1);
        cmp("t1_rdata", 64'(o_res_data), 64'h2ABCD);
        cmp("t1_rch", 64'(o_res_ch), 64'h0);
      end
      if (n == 24) cmp("t1_hold", 64'(o_res_valid), 64'h1);
      tick();
    end

    // Round-robin with all channels requesting
    do_reset();
    vld = '1; rdy = 1'b1; en = 1'b1;
    for (int c = 0; c < 100; c++) begin
      rand_data();
      res_in = DW'($urandom);
      #1;
      if (o_ch_ready != 0) begin
        gc.push_back(c);
        gv.push_back(int'(o_ch_ready));
      end
      tick();
    end
    cmp("t2_ngrants", 64'(gc.size()), 64'(6));
    if (gc.size() >= 5)
      for (int i = 0; i < 5; i++) begin
        cmp("t2_order", 64'(gv[i]), 64'(exp_g[i]));
        cmp("t2_time", 64'(gc[i]), 64'(i * (F + 3)));
      end

    // Backpressure holds the buffer and blocks grants
    do_reset();
    vld = '1; rdy = 1'b0; en = 1'b1;
    cnt = 0;
    for (int c = 0; c < 61; c++) begin
      rand_data();
      res_in = DW'($urandom);
      #1;
      if (c >= 1 && o_ch_ready != 0) cnt++;
      tick();
    end
    cmp("t3_blocked", 64'(cnt), 64'h0);
    rdy = 1'b1;
    #1;
    cmp("t3_regrant", 64'(o_ch_ready), 64'h2);
    tick();

    // Enable dropped mid-frame
    do_reset();
    vld = '1; rdy = 1'b1; en = 1'b1;
    wait_load(ok);
    repeat (6) tick();
    en = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (o_res_valid) cnt++;
      tick();
    end
    cmp("t4_result", 64'(cnt), 64'h1);
    cmp("t4_idle", 64'(o_busy), 64'h0);

    // Reset mid-run forgets the pointer
    do_reset();
    vld = 4'b0100; en = 1'b1; rdy = 1'b1;
    wait_load(ok);
    repeat (9) tick();
    do_reset();
    vld = 4'b0101;
    #1;
    cmp("t5_ready", 64'(o_ch_ready), 64'h1);
    cmp("t5_rvalid", 64'(o_res_valid), 64'h0);
    cmp("t5_run", 64'(o_flt_run), 64'h0);
    tick();

    // Signed extremes pass through untouched
    one_result(18'h20000, "t6_min");
    one_result(18'h1FFFF, "t6_max");

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 399) == 0);
      en     = ($urandom_range(0, 9) != 0);
      rdy    = ($urandom_range(0, 2) != 0);
      vld    = N'($urandom);
      res_in = DW'($urandom);
      rand_data();
      tick();
    end
    rst = 1'b0;
    tick();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
